// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 number feeder: FSM states, glyph table and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t enum, SEG_BLANK / SEG_DASH / DEC_MAX constants, GLYPH_TBL (16 entries).
package seg7_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CONV = 3'd1,
        ENC  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4
    } state_t;

    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [7:0]  SEG_DASH  = 8'hBF;
    localparam logic [31:0] DEC_MAX   = 32'd99_999_999;

    // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for nibble n (0 in the LSB byte).
    localparam logic [15:0][7:0] GLYPH_TBL = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_enc.sv
// Nibble to seven-segment glyph lookup.
// Latency: combinational.
// Backpressure: none.
// Ports: i_nib (4-bit digit value), o_seg (active-low segment byte).
module seg7_hex_enc
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    assign o_seg = GLYPH_TBL[i_nib];

endmodule

// File: rtl/seg7_num_feeder.sv
// Converts a 32-bit number (hex or unsigned decimal) into 8 segment bytes and writes them to seg7 RAM.
// Latency: decimal word0/word1 commit at accept+29/+30; hex or overflow at accept+2/+3.
// Backpressure: in_ready only in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst (sync, active-high); in_valid/in_data/hex_mode/in_ready request side;
//        done pulse with word1; seg_D/seg_A/seg_be/seg_we drive the seg7 write port.
// Optional: define SEG7_LZB_EN to blank leading zeros in decimal mode (digit 0 always shown).
module seg7_num_feeder
    import seg7_pkg::*;
#(
    parameter int DEC_BITS = 27,
    parameter int DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        hex_mode,
    output logic        in_ready,
    output logic        done,
    output logic [31:0] seg_D,
    output logic        seg_A,
    output logic [3:0]  seg_be,
    output logic        seg_we
);

    localparam int                CNT_W    = $clog2(DEC_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEC_BITS - 1);

    state_t                  r_state, w_next;
    logic [4*DIGITS-1:0]     r_bcd;
    logic [DEC_BITS-1:0]     r_bin;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_hex;
    logic                    r_ovf;
    logic [8*DIGITS-1:0]     r_word;

    logic                    w_accept;
    logic [4*DIGITS-1:0]     w_adj;
    logic [DIGITS-1:0]       w_blank;
    logic [7:0]              w_glyph [DIGITS];
    logic [8*DIGITS-1:0]     w_seg;

    assign w_accept = in_valid && (r_state == IDLE);

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    // Per-digit glyph lookup with dash/blank overrides.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                           : r_bcd[4*g +: 4];
        seg7_hex_enc u_enc (
            .i_nib (r_bcd[4*g +: 4]),
            .o_seg (w_glyph[g])
        );
        assign w_seg[8*g +: 8] = r_ovf      ? SEG_DASH  :
                                 w_blank[g] ? SEG_BLANK : w_glyph[g];
    end

`ifdef SEG7_LZB_EN
    // Walk down from the top digit; a digit is blank while every digit from it upward is zero.
    logic w_zrun;
    always_comb begin
        w_blank = '0;
        w_zrun  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zrun     = w_zrun && (r_bcd[4*k +: 4] == 4'd0);
            w_blank[k] = w_zrun && !r_hex;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = (!hex_mode && in_data <= DEC_MAX) ? CONV : ENC;
            CONV: if (r_cnt == CNT_LAST) w_next = ENC;
            ENC:  w_next = WR0;
            WR0:  w_next = WR1;
            WR1:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_hex  <= 1'b0;
            r_ovf  <= 1'b0;
            r_word <= '0;
        end else begin
            if (w_accept) begin
                r_hex <= hex_mode;
                r_ovf <= !hex_mode && (in_data > DEC_MAX);
                r_cnt <= '0;
                r_bin <= in_data[DEC_BITS-1:0];
                // Hex reuses the BCD register as a plain nibble vector so ENC has one source.
                r_bcd <= hex_mode ? in_data : '0;
            end else if (r_state == CONV) begin
                r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[DEC_BITS-1]};
                r_bin <= {r_bin[DEC_BITS-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == ENC) begin
                r_word <= w_seg;
            end
        end
    end

    assign seg_be = 4'hF;

    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        seg_we   = 1'b0;
        seg_A    = 1'b0;
        seg_D    = '0;
        case (r_state)
            IDLE: in_ready = 1'b1;
            WR0: begin
                seg_we = 1'b1;
                seg_D  = r_word[31:0];
            end
            WR1: begin
                seg_we = 1'b1;
                seg_A  = 1'b1;
                seg_D  = r_word[63:32];
                done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seg7_num_feeder.sv
// Self-checking bench for seg7_num_feeder: scoreboard of expected seg7 writes with commit cycles.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_num_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        hex_mode;
    logic        in_ready;
    logic        done;
    logic [31:0] seg_D;
    logic        seg_A;
    logic [3:0]  seg_be;
    logic        seg_we;

    seg7_num_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .hex_mode (hex_mode),
        .in_ready (in_ready),
        .done     (done),
        .seg_D    (seg_D),
        .seg_A    (seg_A),
        .seg_be   (seg_be),
        .seg_we   (seg_we)
    );

    always #5 clk = ~clk;

    // cyc seen at a negedge is the number of the upcoming posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [63:0] model(input logic [31:0] d, input logic hx);
        logic [63:0] r;
        logic [31:0] p;
        logic [3:0]  nib;
        int          dig;
        bit          lzb;
`ifdef SEG7_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        r = '0;
        p = 32'd1;
        for (int k = 0; k < 8; k++) begin
            if (hx) begin
                nib = d[4*k +: 4];
                r[8*k +: 8] = glyph[nib];
            end else if (d > 32'd99_999_999) begin
                r[8*k +: 8] = 8'hBF;
            end else begin
                dig = int'((d / p) % 32'd10);
                if (lzb && k > 0 && d < p) r[8*k +: 8] = 8'hFF;
                else                       r[8*k +: 8] = glyph[dig];
            end
            p = p * 32'd10;
        end
        return r;
    endfunction

    typedef struct {
        logic        a;
        logic [31:0] d;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;

    always @(negedge clk) begin
        if (seg_we) begin
            n_wr++;
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(seg_D), 64'hDEAD_0000_0000);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr",  64'(seg_A),  64'(mon_e.a));
                check("wr_data",  64'(seg_D),  64'(mon_e.d));
                check("wr_cycle", 64'(cyc),    64'(mon_e.cyc));
                check("wr_be",    64'(seg_be), 64'hF);
                check("wr_done",  64'(done),   64'(mon_e.a));
            end
        end else if (done) begin
            check("done_without_write", 64'(done), 64'h0);
        end
    end

    task automatic send(input logic [31:0] d, input logic hx, input logic hold, output int n);
        int          waited;
        int          lat;
        logic [63:0] w;
        wr_t         e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        hex_mode = hx;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'h1);
            in_valid = 1'b0;
            n = -1;
            return;
        end
        n   = cyc;
        w   = model(d, hx);
        lat = (!hx && d <= 32'd99_999_999) ? 29 : 2;
        e.a = 1'b0; e.d = w[31:0];  e.cyc = n + lat;     sb.push_back(e);
        e.a = 1'b1; e.d = w[63:32]; e.cyc = n + lat + 1; sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n, n1, n2, wr_before;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        hex_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_done",     64'(done),     64'h0);
        check("rst_seg_we",   64'(seg_we),   64'h0);
        check("rst_seg_A",    64'(seg_A),    64'h0);
        check("rst_seg_D",    64'(seg_D),    64'h0);
        check("rst_seg_be",   64'(seg_be),   64'hF);
        rst = 1'b0;

        // Main patterns and boundaries.
        send(32'd12_345_678, 1'b0, 1'b0, n); drain();
        send(32'hDEAD_BEEF,  1'b1, 1'b0, n); drain();
        send(32'd100_000_000, 1'b0, 1'b0, n); drain();
        send(32'd99_999_999, 1'b0, 1'b0, n); drain();
        send(32'd0,          1'b0, 1'b0, n); drain();
        send(32'h0000_0000,  1'b1, 1'b0, n); drain();
        send(32'd1_020,      1'b0, 1'b0, n); drain();
        send(32'hFFFF_FFFF,  1'b0, 1'b0, n); drain();
        send(32'h0123_4567,  1'b1, 1'b0, n); drain();

        // Requests while busy are dropped.
        wr_before = n_wr;
        send(32'd87_654_321, 1'b0, 1'b0, n);
        repeat (5) @(negedge clk);
        check("busy_in_ready", 64'(in_ready), 64'h0);
        in_valid = 1'b1; in_data = 32'h1111_1111; hex_mode = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_in_ready2", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("busy_write_count", 64'(n_wr - wr_before), 64'd2);

        // Reset in the middle of a conversion aborts it with no writes.
        wr_before = n_wr;
        send(32'd55_555_555, 1'b0, 1'b0, n);
        while (cyc != n + 10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", 64'(in_ready), 64'h1);
        repeat (40) @(negedge clk);
        check("rst_mid_writes", 64'(n_wr - wr_before), 64'd0);
        send(32'd42, 1'b0, 1'b0, n); drain();

        // Reset wins over a simultaneous request.
        wr_before = n_wr;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'd7; hex_mode = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("rst_valid_ready", 64'(in_ready), 64'h1);
        repeat (10) @(negedge clk);
        check("rst_valid_writes", 64'(n_wr - wr_before), 64'd0);

        // Back-to-back with in_valid held high.
        send(32'd31_415_926, 1'b0, 1'b1, n1);
        send(32'hCAFE_F00D,  1'b1, 1'b0, n2);
        check("b2b_gap", 64'(n2 - n1), 64'd31);
        drain();

        repeat (5) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
